// File: rtl/sd_block_server.sv
// sd_block_server: responder for the sd_rd/sd_wr/sd_ack block protocol.
// Serves 512-byte blocks from a byte-wide image memory. Blocks at or past
// img_blocks read as zeros and swallow writes.
// Optional macro SD_BLOCK_SERVER_WP_EN adds img_wp/wp_hit (write protect).
module sd_block_server #(
  parameter int IMG_AW   = 18,
  parameter int BYTE_GAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic [15:0]       img_blocks,
  output logic [IMG_AW-1:0] img_addr,
  output logic              img_rd,
  output logic              img_wr,
  output logic [7:0]        img_wdata,
  input  logic [7:0]        img_rdata,
  input  logic              img_ready
`ifdef SD_BLOCK_SERVER_WP_EN
  ,
  input  logic              img_wp,
  output logic              wp_hit
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, GAP, DONE
  } state_t;

  state_t state, state_nx, resume;

  logic [IMG_AW-10:0] lba_r;     // only the bits that reach img_addr
  logic               dir_wr;
  logic               in_range;
  logic [8:0]         idx;
  logic [7:0]         data_r;
  logic [15:0]        gap_cnt;
  logic               accept;
  logic               accept_range;
  logic               byte_end;  // last cycle spent on the current byte
  logic               mem_ok;    // this block may write the image

  assign accept       = (state == IDLE) && (sd_rd || sd_wr);
  assign accept_range = sd_lba < {16'd0, img_blocks};

`ifdef SD_BLOCK_SERVER_WP_EN
  logic wp_r;
  assign mem_ok = in_range && !wp_r;
  assign wp_hit = (state == DONE) && wp_r;
`else
  assign mem_ok = in_range;
`endif

  // Outputs are pure decodes of state, so reset clears them immediately.
  assign sd_ack       = (state != IDLE) && (state != DONE);
  assign sd_buff_wr   = (state == RD_PUT);
  assign sd_buff_addr = idx;
  assign sd_buff_dout = data_r;
  assign img_wdata    = data_r;
  assign img_rd       = (state == RD_REQ) || (state == RD_WAIT);
  assign img_wr       = (state == WR_MEM) && mem_ok;
  assign img_addr     = {lba_r, idx};

  // Next-state: per-byte sub-sequence, then a common advance/finish step.
  always_comb begin
    state_nx = state;
    byte_end = 1'b0;
    resume   = dir_wr ? WR_ADDR : (in_range ? RD_REQ : RD_PUT);
    case (state)
      IDLE: begin
        if (sd_rd)      state_nx = accept_range ? RD_REQ : RD_PUT;
        else if (sd_wr) state_nx = WR_ADDR;
      end
      RD_REQ, RD_WAIT: state_nx = img_ready ? RD_PUT : RD_WAIT;
      RD_PUT:          byte_end = 1'b1;
      WR_ADDR:         state_nx = WR_CAP;
      WR_CAP: begin
        // Protected in-range blocks still spend the WR_MEM cycle so ack
        // timing matches an ordinary write.
        if (in_range) state_nx = WR_MEM;
        else          byte_end = 1'b1;
      end
      WR_MEM:          if (img_ready || !mem_ok) byte_end = 1'b1;
      GAP:             if (gap_cnt == 16'(BYTE_GAP - 1)) state_nx = resume;
      DONE:            state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
    if (byte_end)
      state_nx = (idx == 9'd511) ? DONE : ((BYTE_GAP > 0) ? GAP : resume);
  end

  // State, request latch, byte index, data holding register and gap pacing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lba_r    <= '0;
      dir_wr   <= 1'b0;
      in_range <= 1'b0;
      idx      <= '0;
      data_r   <= '0;
      gap_cnt  <= '0;
`ifdef SD_BLOCK_SERVER_WP_EN
      wp_r     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        lba_r    <= sd_lba[IMG_AW-10:0];
        dir_wr   <= !sd_rd;
        in_range <= accept_range;
        idx      <= '0;
        data_r   <= '0;  // out-of-range reads never reload this
`ifdef SD_BLOCK_SERVER_WP_EN
        wp_r     <= !sd_rd && img_wp;
`endif
      end
      if (img_rd && img_ready) data_r <= img_rdata;
      if (state == WR_CAP)     data_r <= sd_buff_din;
      if (byte_end) begin
        gap_cnt <= '0;
        idx     <= (idx == 9'd511) ? 9'd0 : idx + 9'd1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_server.sv
// Bench for sd_block_server: image memory model, requester buffer model and
// a scoreboard of expected read strobes popped by a monitor.
module tb_sd_block_server;

  logic        clk, reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic [15:0] img_blocks;
  logic [17:0] img_addr;
  logic        img_rd, img_wr, img_ready;
  logic [7:0]  img_wdata, img_rdata;
`ifdef SD_BLOCK_SERVER_WP_EN
  logic        img_wp, wp_hit;
`endif

  sd_block_server #(.IMG_AW(18), .BYTE_GAP(0)) dut (
    .clk(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_blocks(img_blocks),
    .img_addr(img_addr), .img_rd(img_rd), .img_wr(img_wr), .img_wdata(img_wdata),
    .img_rdata(img_rdata), .img_ready(img_ready)
`ifdef SD_BLOCK_SERVER_WP_EN
    , .img_wp(img_wp), .wp_hit(wp_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [31:0] kk;
    kk = k;
    return kk[7:0] ^ kk[15:8];
  endfunction

  // Image memory: initialised on the first clock, written on handshakes.
  logic [7:0] mem [0:262143];
  logic       init_done = 1'b0;
  logic       fast = 1'b1;
  logic [2:0] wcnt = '0, lat = '0;
  int         n_imgwr = 0, n_imgrd = 0, n_bwr = 0, n_wp = 0;

  assign img_ready = fast ? 1'b1 : ((img_rd || img_wr) && (wcnt >= lat));
  assign img_rdata = mem[img_addr];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 262144; k++) mem[k] <= pat(k);
      init_done <= 1'b1;
    end else if (img_wr && img_ready) begin
      mem[img_addr] <= img_wdata;
    end
    if (img_rd || img_wr) begin
      if (img_ready) begin
        wcnt <= '0;
        lat  <= 3'($urandom_range(0, 3));
      end else begin
        wcnt <= wcnt + 3'd1;
      end
    end
    if (img_wr && img_ready) n_imgwr <= n_imgwr + 1;
    if (img_rd)              n_imgrd <= n_imgrd + 1;
    if (sd_buff_wr)          n_bwr   <= n_bwr + 1;
`ifdef SD_BLOCK_SERVER_WP_EN
    if (wp_hit)              n_wp    <= n_wp + 1;
`endif
  end

  // Requester buffer: byte i holds ~i, presented one cycle after the address.
  always @(posedge clk) sd_buff_din <= ~sd_buff_addr[7:0];

  typedef struct { logic [8:0] a; logic [7:0] d; } exp_t;
  exp_t sb[$];
  int   n_strobe = 0;

  task automatic push_blk(input int lba, input bit zero);
    exp_t e;
    for (int i = 0; i < 512; i++) begin
      e.a = 9'(i);
      e.d = zero ? 8'h00 : pat(lba * 512 + i);
      sb.push_back(e);
    end
  endtask

  // Monitor: every read strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && sd_buff_wr) begin
      exp_t e;
      n_strobe++;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_strobe: got addr %0h data %0h expected none", sd_buff_addr, sd_buff_dout);
      end else begin
        e = sb.pop_front();
        chk("strobe_addr", 32'(sd_buff_addr), 32'(e.a));
        chk("strobe_data", 32'(sd_buff_dout), 32'(e.d));
        chk("strobe_ack",  32'(sd_ack), 32'd1);
      end
    end
  end

  // One request from a negedge; returns at the negedge where ack is low.
  // Inputs are disturbed while ack is high to show they are ignored.
  task automatic req(input logic [31:0] lba, input logic wr, output int acc, output int hi);
    logic [15:0] blk_save;
    blk_save = img_blocks;
    sd_lba = lba;
    if (wr) sd_wr = 1'b1; else sd_rd = 1'b1;
    acc = 0;
    while (!sd_ack && acc < 20) begin @(negedge clk); acc++; end
    if (!sd_ack) begin
      chk("accept_timeout", 32'(sd_ack), 32'd1);
      sd_rd = 1'b0; sd_wr = 1'b0;
      hi = 0;
      return;
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
    sd_lba = 32'hFFFF_FFFF;
    img_blocks = 16'hFFFF;
    hi = 0;
    while (sd_ack && hi < 20000) begin
      @(negedge clk); hi++;
      if (hi == 5)  begin sd_rd = wr; sd_wr = !wr; end
      if (hi == 10) begin sd_rd = 1'b0; sd_wr = 1'b0; end
    end
    if (sd_ack) chk("ack_timeout", 32'(sd_ack), 32'd0);
    img_blocks = blk_save;
  endtask

  int acc, hi, s_wr, s_rd, s_bwr, s_wp, errs, bad;

  initial begin
    reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; img_blocks = 16'd455;
`ifdef SD_BLOCK_SERVER_WP_EN
    img_wp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack",     32'(sd_ack), 32'd0);
    chk("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
    chk("rst_img_rd",  32'(img_rd), 32'd0);
    chk("rst_img_wr",  32'(img_wr), 32'd0);
    chk("rst_baddr",   32'(sd_buff_addr), 32'd0);
    chk("rst_iaddr",   32'(img_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read lba 3 from idle.
    push_blk(3, 1'b0);
    s_wr = n_imgwr;
    req(32'd3, 1'b0, acc, hi);
    chk("rd3_accept", 32'(acc), 32'd1);
    chk("rd3_ack_len", 32'(hi), 32'd1024);
    chk("rd3_sb_empty", 32'(sb.size()), 32'd0);
    chk("rd3_no_imgwr", 32'(n_imgwr - s_wr), 32'd0);

    // Write lba 10 with buffer byte i = ~i.
    s_wr = n_imgwr; s_bwr = n_bwr;
    req(32'd10, 1'b1, acc, hi);
    chk("wr10_ack_len", 32'(hi), 32'd1536);
    @(negedge clk);
    chk("wr10_imgwr", 32'(n_imgwr - s_wr), 32'd512);
    chk("wr10_no_bwr", 32'(n_bwr - s_bwr), 32'd0);
    errs = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [31:0] iv;
      iv = i;
      if (mem[5120 + i] !== ~iv[7:0]) begin errs++; bad = i; end
    end
    chk("wr10_image_errs", 32'(errs), 32'd0);
    if (errs != 0) $display("  first bad index near %0d", bad);

    // Out-of-range read and write.
    push_blk(455, 1'b1);
    s_rd = n_imgrd;
    req(32'd455, 1'b0, acc, hi);
    chk("oor_rd_ack_len", 32'(hi), 32'd512);
    chk("oor_rd_no_imgrd", 32'(n_imgrd - s_rd), 32'd0);
    s_wr = n_imgwr;
    req(32'd500, 1'b1, acc, hi);
    chk("oor_wr_ack_len", 32'(hi), 32'd1024);
    chk("oor_wr_no_imgwr", 32'(n_imgwr - s_wr), 32'd0);
    errs = 0;
    for (int k = 256000; k < 256512; k++) if (mem[k] !== pat(k)) errs++;
    chk("oor_wr_image_errs", 32'(errs), 32'd0);

    // Track 2 fetch, back to back, random memory latency.
    fast = 1'b0;
    for (int b = 0; b < 13; b++) begin
      push_blk(26 + b, 1'b0);
      req(32'(26 + b), 1'b0, acc, hi);
      chk("trk_b2b_accept", 32'(acc), 32'd2);
    end
    chk("trk_sb_empty", 32'(sb.size()), 32'd0);
    fast = 1'b1;

    // Reset at byte 200 of a read.
    push_blk(7, 1'b0);
    s_rd = n_strobe;
    sd_lba = 32'd7; sd_rd = 1'b1;
    acc = 0;
    while (!sd_ack && acc < 20) begin @(negedge clk); acc++; end
    sd_rd = 1'b0;
    hi = 0;
    while ((n_strobe - s_rd) < 200 && hi < 5000) begin @(posedge clk); hi++; end
    chk("mid_strobes", 32'(n_strobe - s_rd), 32'd200);
    #2;
    chk("mid_pre_ack", 32'(sd_ack), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(sd_ack), 32'd0);
    chk("mid_rst_bwr", 32'(sd_buff_wr), 32'd0);
    chk("mid_rst_imgrd", 32'(img_rd), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_idle_ack", 32'(sd_ack), 32'd0);

    push_blk(0, 1'b0);
    req(32'd0, 1'b0, acc, hi);
    chk("rd0_accept", 32'(acc), 32'd1);
    chk("rd0_ack_len", 32'(hi), 32'd1024);

`ifdef SD_BLOCK_SERVER_WP_EN
    img_wp = 1'b1;
    s_wr = n_imgwr; s_wp = n_wp;
    req(32'd1, 1'b1, acc, hi);
    img_wp = 1'b0;
    chk("wp_ack_len", 32'(hi), 32'd1536);
    repeat (2) @(negedge clk);
    chk("wp_no_imgwr", 32'(n_imgwr - s_wr), 32'd0);
    chk("wp_hit_pulses", 32'(n_wp - s_wp), 32'd1);
    errs = 0;
    for (int k = 512; k < 1024; k++) if (mem[k] !== pat(k)) errs++;
    chk("wp_image_errs", 32'(errs), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_block_server.md
Name: sd_block_server

Overview:
- Responder end of the sd_rd/sd_wr/sd_ack block protocol used by floppy_track and other disk clients.
- Serves 512-byte block reads and writes from a byte-wide image memory (BRAM or SDRAM port) instead of the HPS.
- Used in standalone and simulation builds, where a disk image is preloaded into RAM.
- One instance serves one requester.

Parameters:
- IMG_AW, 18, image memory byte-address width (2^18 covers a 35-track, 232960-byte image).
- BYTE_GAP, 0, extra idle cycles inserted between consecutive bytes on the buffer side (pacing for bench stress).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sd_lba  in  32  block number; sampled at request accept
- sd_rd  in  1  read request level; requester holds it until sd_ack is high
- sd_wr  in  1  write request level; same rules as sd_rd
- sd_ack  out  1  high for the whole block transfer
- sd_buff_addr  out  9  byte index within the block
- sd_buff_dout  out  8  read data to the requester buffer
- sd_buff_din  in  8  requester buffer data; valid 1 cycle after sd_buff_addr
- sd_buff_wr  out  1  one-cycle strobe; requester writes sd_buff_dout at sd_buff_addr
- img_blocks  in  16  image size in blocks; 0 means no image mounted
- img_addr  out  IMG_AW  image byte address
- img_rd  out  1  memory read request, held until img_ready
- img_wr  out  1  memory write request, held until img_ready
- img_wdata  out  8  memory write data
- img_rdata  in  8  memory read data; valid in the img_ready cycle
- img_ready  in  1  memory completion; may be high in the first request cycle

Behaviour:
- Reset (async): state IDLE; all outputs 0, including sd_ack, sd_buff_wr, img_rd, img_wr, sd_buff_addr and img_addr.
  - Reset mid-transfer abandons the block: no further strobes, and an in-flight memory request is dropped.
- IDLE:
  - If sd_rd or sd_wr is high: latch sd_lba and the direction; sd_ack goes high on the next cycle; byte index i = 0.
  - sd_rd wins if both are high.
- In-range test: range = (lba < img_blocks), zero-extended 32-bit compare, evaluated at accept.
- Memory address: img_addr = (lba*512 + i) truncated to IMG_AW.
- Read path states: RD_REQ -> RD_WAIT -> RD_PUT -> (GAP) -> RD_REQ.
  - RD_REQ: assert img_rd with img_addr.
  - RD_WAIT: hold until img_ready; capture img_rdata in that cycle and drop img_rd.
  - RD_PUT: one cycle with sd_buff_wr=1, sd_buff_addr=i, sd_buff_dout=data.
  - Out of range: skip memory; data 0x00; one byte per (1+BYTE_GAP) cycles.
- Write path states: WR_ADDR -> WR_CAP -> WR_MEM -> (GAP) -> WR_ADDR.
  - WR_ADDR: drive sd_buff_addr=i.
  - WR_CAP: capture sd_buff_din.
  - WR_MEM: assert img_wr with img_wdata until img_ready.
  - Out of range: the address walk still runs; WR_MEM is skipped and data is discarded.
- Index: i increments after each byte.
  - After byte 511, go to DONE (9-bit wrap is never used to continue).
  - sd_buff_wr is never asserted during writes.
- DONE: drop sd_ack; spend exactly 1 cycle with sd_ack low, then return to IDLE.
  - A request seen in IDLE on the following cycle is accepted normally. This supports the requester's back-to-back 13-block track sequence, where the next request follows the ack falling edge.
- sd_rd/sd_wr changes while sd_ack is high are ignored.
- sd_lba changes after accept are ignored.
- img_blocks changing mid-block has no effect on that block.

Optional Feature:
- Macro SD_BLOCK_SERVER_WP_EN.
- Defined: adds ports img_wp (in, 1) and wp_hit (out, 1, reset 0).
  - A write accepted while img_wp=1 runs the full protocol (512 address steps, ack timing unchanged) but never asserts img_wr.
  - wp_hit pulses 1 cycle at DONE of that block.
- Not defined: no extra ports; writes are governed only by range.

Test Plan:
- Image byte[k] = k[7:0] ^ k[15:8], img_blocks=455, img_ready held 1; read lba 3 -> 512 sd_buff_wr strobes, addr 0..511, data (1536+i) pattern; sd_ack high start to end; 1 low cycle after.
- Write lba 10, requester buffer byte i = ~i[7:0] -> image bytes 5120..5631 = ~i; img_wr count 512; sd_buff_wr never high.
- Read lba 455 with img_blocks=455 -> 512 strobes of 0x00, no img_rd; write lba 500 -> image unchanged.
- floppy_track-style requester fetches track 2 (lba 26..38, 13 blocks); img_ready random 1-4 cycle latency -> all 6656 bytes correct; every request accepted.
- Reset asserted at byte 200 of a read -> sd_ack, sd_buff_wr and img_rd go 0 immediately; next read of lba 0 completes correctly.
- With SD_BLOCK_SERVER_WP_EN, img_wp=1, write lba 1 -> image unchanged; wp_hit exactly 1 pulse; ack timing identical to an unprotected write.
